alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 31 +++
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter_rr_grant.sv | 43 ++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared state encoding, ALU select codes and defaults for alu_arbiter
package alu_arb_pkg;

  localparam int ALU_ARB_WIDTH   = 32;
  localparam int ALU_ARB_NUM_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  // Codes 1011..1110 are compare-and-branch ops whose useful output is the branch flag
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_BLT   = 4'b1011;
  localparam logic [3:0] ALU_BGE   = 4'b1100;
  localparam logic [3:0] ALU_BLTU  = 4'b1101;
  localparam logic [3:0] ALU_BGEU  = 4'b1110;
  localparam logic [3:0] ALU_NOP   = 4'b1111;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-port bundle for alu_arbiter
interface alu_arbiter_if
  import alu_arb_pkg::*;
#(
  parameter int Width   = ALU_ARB_WIDTH,
  parameter int NUM_REQ = ALU_ARB_NUM_REQ
);

  logic [NUM_REQ-1:0]            Req_Valid;
  logic [NUM_REQ-1:0]            Req_Ready;
  logic [NUM_REQ-1:0][Width-1:0] Req_Data1;
  logic [NUM_REQ-1:0][Width-1:0] Req_Data2;
  logic [NUM_REQ-1:0][3:0]       Req_Sel;

  logic [NUM_REQ-1:0]            Rsp_Valid;
  logic [NUM_REQ-1:0]            Rsp_Ready;
  logic [Width-1:0]              Rsp_Result;
  logic                          Rsp_Zero;
  logic                          Rsp_BFlag;

  logic [Width-1:0]              ALU_Data1;
  logic [Width-1:0]              ALU_Data2;
  logic [3:0]                    ALU_Select;
  logic [Width-1:0]              ALU_Out;
  logic                          ALU_Zero;
  logic                          ALU_BFlag;

  // master: requesters plus the external ALU; slave: the arbiter
  modport master (
    output Req_Valid, Req_Data1, Req_Data2, Req_Sel, Rsp_Ready,
    output ALU_Out, ALU_Zero, ALU_BFlag,
    input  Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Zero, Rsp_BFlag,
    input  ALU_Data1, ALU_Data2, ALU_Select
  );

  modport slave (
    input  Req_Valid, Req_Data1, Req_Data2, Req_Sel, Rsp_Ready,
    input  ALU_Out, ALU_Zero, ALU_BFlag,
    output Req_Ready, Rsp_Valid, Rsp_Result, Rsp_Zero, Rsp_BFlag,
    output ALU_Data1, ALU_Data2, ALU_Select
  );

endinterface

// File: rtl/alu_arbiter_rr_grant.sv
// rtl/alu_arbiter_rr_grant.sv - combinational one-hot grant; ALU_ARB_RR_EN selects rotating
// search from i_ptr, otherwise lowest index wins.
module rr_grant #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;

`ifdef ALU_ARB_RR_EN
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_req[i] && (i == ((int'(i_ptr) + off) % NUM_REQ))) begin
          o_grant[i] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external single-cycle ALU among NUM_REQ requesters.
// ALU_ARB_RR_EN: round-robin grant; undefined: fixed priority (lowest index).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int Width   = ALU_ARB_WIDTH,
  parameter int NUM_REQ = ALU_ARB_NUM_REQ
) (
  input  logic         CLK,
  input  logic         RST_N,
  alu_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [Width-1:0]   r_alu_data1;
  logic [Width-1:0]   r_alu_data2;
  logic [3:0]         r_alu_select;
  logic [Width-1:0]   r_rsp_result;
  logic               r_rsp_zero;
  logic               r_rsp_bflag;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_ptr_next;

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_grant (
    .i_req   (bus.Req_Valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gidx = PTR_W'(i);
    end
  end

`ifdef ALU_ARB_RR_EN
  assign w_ptr_next = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + PTR_W'(1);
`else
  assign w_ptr_next = '0;
`endif

  // Gated by RST_N so no requester sees an accept while reset is held
  assign w_req_ready = ((r_state == ARB_IDLE) && RST_N) ? w_grant : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= ARB_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_rsp_valid  <= '0;
      r_alu_data1  <= '0;
      r_alu_data2  <= '0;
      r_alu_select <= ALU_NOP;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_bflag  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|w_grant) begin
            r_alu_data1  <= bus.Req_Data1[w_gidx];
            r_alu_data2  <= bus.Req_Data2[w_gidx];
            r_alu_select <= bus.Req_Sel[w_gidx];
            r_owner      <= w_gidx;
            r_ptr        <= w_ptr_next;
            r_state      <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          r_rsp_result <= bus.ALU_Out;
          r_rsp_zero   <= bus.ALU_Zero;
          r_rsp_bflag  <= bus.ALU_BFlag;
          r_rsp_valid  <= NUM_REQ'(1) << r_owner;
          r_state      <= ARB_RESP;
        end
        ARB_RESP: begin
          if (bus.Rsp_Ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_state     <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.Req_Ready  = w_req_ready;
  assign bus.Rsp_Valid  = r_rsp_valid;
  assign bus.Rsp_Result = r_rsp_result;
  assign bus.Rsp_Zero   = r_rsp_zero;
  assign bus.Rsp_BFlag  = r_rsp_bflag;
  assign bus.ALU_Data1  = r_alu_data1;
  assign bus.ALU_Data2  = r_alu_data2;
  assign bus.ALU_Select = r_alu_select;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural external ALU
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 32;
  localparam int N = 2;

  logic CLK;
  logic RST_N;

  alu_arbiter_if #(.Width(W), .NUM_REQ(N)) bus ();

  alu_arbiter #(.Width(W), .NUM_REQ(N)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    int         owner;
    logic [W-1:0] res;
    logic       zero;
    logic       bflag;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   exp_ptr = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // External ALU the arbiter drives
  logic [W-1:0] alu_r;
  logic         alu_bf;
  always_comb begin
    alu_r  = '0;
    alu_bf = 1'b0;
    case (bus.ALU_Select)
      ALU_ADD:   alu_r = bus.ALU_Data1 + bus.ALU_Data2;
      ALU_SUB:   alu_r = bus.ALU_Data1 - bus.ALU_Data2;
      ALU_AND:   alu_r = bus.ALU_Data1 & bus.ALU_Data2;
      ALU_OR:    alu_r = bus.ALU_Data1 | bus.ALU_Data2;
      ALU_XOR:   alu_r = bus.ALU_Data1 ^ bus.ALU_Data2;
      ALU_SLL:   alu_r = bus.ALU_Data1 << bus.ALU_Data2[4:0];
      ALU_SRL:   alu_r = bus.ALU_Data1 >> bus.ALU_Data2[4:0];
      ALU_SRA:   alu_r = $signed(bus.ALU_Data1) >>> bus.ALU_Data2[4:0];
      ALU_SLT:   alu_r = {31'd0, $signed(bus.ALU_Data1) < $signed(bus.ALU_Data2)};
      ALU_SLTU:  alu_r = {31'd0, bus.ALU_Data1 < bus.ALU_Data2};
      ALU_PASSB: alu_r = bus.ALU_Data2;
      ALU_BLT:   alu_bf = $signed(bus.ALU_Data1) < $signed(bus.ALU_Data2);
      ALU_BGE:   alu_bf = $signed(bus.ALU_Data1) >= $signed(bus.ALU_Data2);
      ALU_BLTU:  alu_bf = bus.ALU_Data1 < bus.ALU_Data2;
      ALU_BGEU:  alu_bf = bus.ALU_Data1 >= bus.ALU_Data2;
      default:   alu_r = '0;
    endcase
  end
  assign bus.ALU_Out   = alu_r;
  assign bus.ALU_Zero  = (alu_r == '0);
  assign bus.ALU_BFlag = alu_bf;

  task automatic set_req(input bit idx, input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Req_Sel[idx]   = sel;
    bus.Req_Data1[idx] = a;
    bus.Req_Data2[idx] = b;
  endtask

  task automatic wait_rdy(output logic [N-1:0] rdy, output bit to);
    to  = 1'b1;
    rdy = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.Req_Ready != '0) begin
        rdy = bus.Req_Ready;
        to  = 1'b0;
        break;
      end
      @(negedge CLK); #1;
    end
  endtask

  task automatic wait_rsp(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.Rsp_Valid != '0) begin
        to = 1'b0;
        break;
      end
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    RST_N         = 1'b0;
    bus.Req_Valid = 2'b11;
    bus.Rsp_Ready = 2'b11;
    set_req(0, ALU_ADD, 32'd0, 32'd0);
    set_req(1, ALU_ADD, 32'd0, 32'd0);
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (bus.Req_Ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", bus.Req_Ready); end
    checks++; if (bus.Rsp_Valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 00", bus.Rsp_Valid); end
    checks++; if (bus.Rsp_Result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %0h exp 0", bus.Rsp_Result); end
    checks++; if (bus.Rsp_Zero !== 1'b0 || bus.Rsp_BFlag !== 1'b0) begin errors++; $display("FAIL reset_rsp_flags: got %b%b exp 00", bus.Rsp_Zero, bus.Rsp_BFlag); end
    checks++; if (bus.ALU_Data1 !== 32'd0 || bus.ALU_Data2 !== 32'd0) begin errors++; $display("FAIL reset_alu_data: got %0h %0h exp 0 0", bus.ALU_Data1, bus.ALU_Data2); end
    checks++; if (bus.ALU_Select !== 4'b1111) begin errors++; $display("FAIL reset_alu_select: got %b exp 1111", bus.ALU_Select); end
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    RST_N         = 1'b1;
    exp_ptr       = 0;
  endtask

  task automatic test_single_op;
    logic [N-1:0] rdy;
    bit to;
    exp_t e;
    @(negedge CLK);
    set_req(0, ALU_SUB, 32'd5, 32'd3);
    bus.Req_Valid = 2'b01;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to) begin errors++; $display("FAIL single_ready_timeout: got none exp 01"); end
    checks++; if (rdy !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", rdy); end
    sb.push_back('{0, 32'd2, 1'b0, 1'b0});
    exp_ptr = 1;
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    #1;
    checks++; if (bus.ALU_Data1 !== 32'd5 || bus.ALU_Data2 !== 32'd3 || bus.ALU_Select !== ALU_SUB) begin errors++; $display("FAIL single_alu_ops: got %0h %0h %b exp 5 3 0001", bus.ALU_Data1, bus.ALU_Data2, bus.ALU_Select); end
    checks++; if (bus.Rsp_Valid !== 2'b00 || bus.Req_Ready !== 2'b00) begin errors++; $display("FAIL single_exec_idle: got rsp %b rdy %b exp 00 00", bus.Rsp_Valid, bus.Req_Ready); end
    @(negedge CLK); #1;
    checks++; if (bus.Rsp_Valid !== 2'b01) begin errors++; $display("FAIL single_rsp_latency: got %b exp 01", bus.Rsp_Valid); end
    e = sb.pop_front();
    checks++; if (bus.Rsp_Result !== e.res || bus.Rsp_Zero !== e.zero) begin errors++; $display("FAIL single_result: got %0h z%b exp %0h z%b", bus.Rsp_Result, bus.Rsp_Zero, e.res, e.zero); end
  endtask

  task automatic test_contention;
    logic [N-1:0] rdy;
    logic [N-1:0] exp_g;
    bit to;
    int last;
    int own;
    exp_t e;
    last = 0;
    @(negedge CLK);
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(1, ALU_ADD, 32'd2, 32'd2);
    bus.Req_Valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_rdy(rdy, to);
      checks++; if (to) begin errors++; $display("FAIL contend_ready_timeout[%0d]: got none", k); end
`ifdef ALU_ARB_RR_EN
      own = exp_ptr;
`else
      own = 0;
`endif
      exp_g = (own == 1) ? 2'b10 : 2'b01;
      checks++; if (rdy !== exp_g) begin errors++; $display("FAIL contend_grant[%0d]: got %b exp %b", k, rdy, exp_g); end
      if (k > 0) begin
        checks++; if (cyc - last !== 3) begin errors++; $display("FAIL contend_spacing[%0d]: got %0d exp 3", k, cyc - last); end
      end
      last = cyc;
      sb.push_back('{own, (own == 1) ? 32'd4 : 32'd2, 1'b0, 1'b0});
      exp_ptr = own ^ 1;
      wait_rsp(to);
      checks++; if (to) begin errors++; $display("FAIL contend_rsp_timeout[%0d]: got none", k); end
      e = sb.pop_front();
      checks++; if (bus.Rsp_Valid !== ((e.owner == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contend_rsp_owner[%0d]: got %b exp owner %0d", k, bus.Rsp_Valid, e.owner); end
      checks++; if (bus.Rsp_Result !== e.res) begin errors++; $display("FAIL contend_result[%0d]: got %0d exp %0d", k, bus.Rsp_Result, e.res); end
    end
    bus.Req_Valid = 2'b00;
    @(negedge CLK); #1;
  endtask

  task automatic test_backpressure;
    logic [N-1:0] rdy;
    bit to;
    exp_t e;
    bus.Rsp_Ready = 2'b01;
    @(negedge CLK);
    set_req(1, ALU_BLT, 32'hFFFF_FFFF, 32'd1);
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    bus.Req_Valid = 2'b10;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to || rdy !== 2'b10) begin errors++; $display("FAIL bp_grant: got %b exp 10", rdy); end
    sb.push_back('{1, 32'd0, 1'b1, 1'b1});
    exp_ptr = 0;
    @(negedge CLK);
    bus.Req_Valid = 2'b01;
    #1;
    wait_rsp(to);
    checks++; if (to) begin errors++; $display("FAIL bp_rsp_timeout: got none"); end
    e = sb.pop_front();
    checks++; if (bus.Rsp_Valid !== 2'b10 || bus.Rsp_BFlag !== e.bflag) begin errors++; $display("FAIL bp_first_rsp: got %b bf%b exp 10 bf%b", bus.Rsp_Valid, bus.Rsp_BFlag, e.bflag); end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      checks++; if (bus.Rsp_Valid !== 2'b10 || bus.Rsp_BFlag !== e.bflag || bus.Req_Ready !== 2'b00) begin errors++; $display("FAIL bp_stall[%0d]: got rsp %b bf%b rdy %b exp 10 bf1 00", k, bus.Rsp_Valid, bus.Rsp_BFlag, bus.Req_Ready); end
    end
    @(negedge CLK);
    bus.Rsp_Ready = 2'b11;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to || rdy !== 2'b01) begin errors++; $display("FAIL bp_next_grant: got %b exp 01", rdy); end
    sb.push_back('{0, 32'd2, 1'b0, 1'b0});
    exp_ptr = 1;
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    #1;
    wait_rsp(to);
    e = sb.pop_front();
    checks++; if (to || bus.Rsp_Valid !== 2'b01 || bus.Rsp_Result !== e.res) begin errors++; $display("FAIL bp_next_rsp: got %b %0d exp 01 %0d", bus.Rsp_Valid, bus.Rsp_Result, e.res); end
  endtask

  task automatic test_unused_sel;
    logic [N-1:0] rdy;
    bit to;
    exp_t e;
    @(negedge CLK);
    set_req(0, ALU_NOP, 32'd7, 32'd0);
    bus.Req_Valid = 2'b01;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to || rdy !== 2'b01) begin errors++; $display("FAIL nop_grant: got %b exp 01", rdy); end
    sb.push_back('{0, 32'd0, 1'b1, 1'b0});
    exp_ptr = 1;
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    #1;
    wait_rsp(to);
    e = sb.pop_front();
    checks++; if (to || bus.Rsp_Result !== e.res || bus.Rsp_Zero !== e.zero || bus.Rsp_BFlag !== e.bflag) begin errors++; $display("FAIL nop_result: got %0h z%b b%b exp %0h z%b b%b", bus.Rsp_Result, bus.Rsp_Zero, bus.Rsp_BFlag, e.res, e.zero, e.bflag); end
  endtask

  task automatic test_reset_exec;
    logic [N-1:0] rdy;
    bit to;
    exp_t e;
    @(negedge CLK);
    set_req(0, ALU_ADD, 32'd9, 32'd9);
    bus.Req_Valid = 2'b01;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to || rdy !== 2'b01) begin errors++; $display("FAIL rst_exec_grant: got %b exp 01", rdy); end
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    RST_N         = 1'b0;
    #1;
    checks++; if (bus.ALU_Data1 !== 32'd9) begin errors++; $display("FAIL rst_exec_in_exec: got %0d exp 9", bus.ALU_Data1); end
    @(negedge CLK);
    RST_N   = 1'b1;
    exp_ptr = 0;
    #1;
    checks++; if (bus.Rsp_Valid !== 2'b00 || bus.Req_Ready !== 2'b00) begin errors++; $display("FAIL rst_exec_valids: got rsp %b rdy %b exp 00 00", bus.Rsp_Valid, bus.Req_Ready); end
    checks++; if (bus.Rsp_Result !== 32'd0 || bus.Rsp_Zero !== 1'b0 || bus.Rsp_BFlag !== 1'b0) begin errors++; $display("FAIL rst_exec_rsp: got %0h z%b b%b exp 0 z0 b0", bus.Rsp_Result, bus.Rsp_Zero, bus.Rsp_BFlag); end
    checks++; if (bus.ALU_Data1 !== 32'd0 || bus.ALU_Data2 !== 32'd0 || bus.ALU_Select !== 4'b1111) begin errors++; $display("FAIL rst_exec_alu: got %0h %0h %b exp 0 0 1111", bus.ALU_Data1, bus.ALU_Data2, bus.ALU_Select); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); #1;
      checks++; if (bus.Rsp_Valid !== 2'b00) begin errors++; $display("FAIL rst_exec_no_rsp[%0d]: got %b exp 00", k, bus.Rsp_Valid); end
    end
    @(negedge CLK);
    set_req(1, ALU_ADD, 32'd10, 32'd20);
    bus.Req_Valid = 2'b10;
    #1;
    wait_rdy(rdy, to);
    checks++; if (to || rdy !== 2'b10) begin errors++; $display("FAIL rst_rereq_grant: got %b exp 10", rdy); end
    sb.push_back('{1, 32'd30, 1'b0, 1'b0});
    @(negedge CLK);
    bus.Req_Valid = 2'b00;
    #1;
    wait_rsp(to);
    e = sb.pop_front();
    checks++; if (to || bus.Rsp_Valid !== 2'b10 || bus.Rsp_Result !== e.res || bus.Rsp_Zero !== e.zero) begin errors++; $display("FAIL rst_rereq_rsp: got %b %0d z%b exp 10 %0d z%b", bus.Rsp_Valid, bus.Rsp_Result, bus.Rsp_Zero, e.res, e.zero); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_unused_sel();
    test_reset_exec();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

endmodule
